stopwatch_ctrl: RTL
===================

Name: stopwatch_ctrl

Overview:
Control front-end for the stopwatch datapath. Sits directly upstream of the BCD digit counters.
- Debounces the Start/Stop and Clear push-buttons.
- Runs the IDLE/RUN/PAUSE state machine.
- Generates the one-cycle count-enable tick (hundredths rate) and a synchronous clear pulse for the counter chain.

Parameters:
DIV, 500000, clock cycles per Enable tick (50 MHz / 100 Hz); prescaler width = $clog2(DIV)
DB_CYCLES, 500000, consecutive stable cycles required to accept a new button level (10 ms at 50 MHz)

Ports:
Clk  input  1  system clock; all logic on rising edge
Reset  input  1  synchronous, active-high reset
Start_Stop_btn  input  1  raw asynchronous push-button, active-high
Clear_btn  input  1  raw asynchronous push-button, active-high
Enable  output  1  one-cycle count tick to the first BCD counter
Clear_out  output  1  one-cycle synchronous clear pulse to all counters
Running  output  1  high while in RUN
Paused  output  1  high while in PAUSE

Behaviour:
- Reset (Reset=1 at a Clk edge) sets the following to 0:
  - FSM state (IDLE), prescaler, debounce counters, debounced levels, synchronizers.
  - Outputs Enable, Clear_out, Running, Paused.
- Reset has priority over all other events, including mid-RUN and mid-debounce.
- Input conditioning, per button:
  - 2-flop synchronizer.
  - Debounce counter: clears whenever the synchronized level equals the debounced level; otherwise increments. When it reaches DB_CYCLES-1 the debounced level flips and the counter clears.
  - Press pulse = debounced rising edge, exactly 1 cycle. Release generates nothing.
  - Latency from a clean raw assertion to the press pulse: 2 + DB_CYCLES cycles. The FSM reacts on the next edge.
  - A button held through reset release is seen as a press once debounced.
- FSM:
  - IDLE: ss_press -> RUN. clr_press -> Clear_out=1 for one cycle, stay IDLE.
  - RUN: ss_press -> PAUSE. clr_press ignored.
  - PAUSE: ss_press -> RUN. clr_press -> IDLE, Clear_out=1 for one cycle, prescaler cleared.
  - Simultaneous presses:
    - IDLE: Clear wins, ss ignored.
    - PAUSE: Clear wins, go to IDLE.
    - RUN: ss wins, go to PAUSE.
- Prescaler:
  - Counts 0..DIV-1 only in RUN and wraps to 0.
  - Enable=1 on the cycle the count equals DIV-1 while in RUN, so the period is exactly DIV cycles.
  - Holds its value in PAUSE, so the fractional period is preserved on resume.
  - Zero in IDLE.
  - First Enable after IDLE->RUN occurs DIV cycles after Running rises.
  - If ss_press arrives on the same cycle as the terminal count, Enable still fires and the FSM goes to PAUSE with the prescaler at 0.
- Running and Paused are registered decodes of the state. They are never both 1.
- Enable and Clear_out are registered and are never both 1.

Optional Feature:
Macro: STOPWATCH_LAP_EN
- Defined:
  - Adds input Lap_btn (same conditioning as the other buttons) and output Lap_hold (reset 0).
  - In RUN, a lap press toggles Lap_hold. The display stage freezes while Lap_hold=1; counting continues.
  - In PAUSE, lap presses are ignored and Lap_hold keeps its value.
  - Entering IDLE forces Lap_hold=0.
- Undefined: Lap_btn and Lap_hold do not exist; no lap logic is synthesized.

Test Plan (DIV=10, DB_CYCLES=4):
1. Reset held 3 cycles with both buttons high -> all outputs 0 while Reset=1. After release with buttons still high, Running rises 2+4+1 cycles later.
2. Clean Start_Stop_btn pulse 8 cycles long from IDLE -> Running=1 at cycle 7 after assertion. Enable pulses at Running+10, +20, +30; each pulse is exactly 1 cycle.
3. Start_Stop_btn toggled every 2 cycles for 20 cycles, then held low -> no press pulse, state remains IDLE, Enable never asserts.
4. In RUN, press Start_Stop so PAUSE begins 7 prescaler counts into a period; wait 50 cycles; press again -> no Enable while Paused. First Enable comes 3 cycles after Running reasserts.
5. Clear_btn press in RUN -> no Clear_out, still Running. Clear_btn press in PAUSE -> single-cycle Clear_out, then Paused=0 and Running=0. Clear_btn press in IDLE -> single Clear_out. Both buttons pressed together in PAUSE -> Clear_out, IDLE.
6. Reset asserted 4 cycles into a RUN period -> next edge all outputs 0. A new Start_Stop press then gives its first Enable a full 10 cycles after Running.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | stopwatch_ctrl: button conditioning, IDLE/RUN/PAUSE FSM, hundredths tick.    |
// | Optional lap-hold feature: define STOPWATCH_LAP_EN.   Revision: 1.0          |
// +----------------------------------------------------------------------------+
module stopwatch_ctrl #(
  parameter int DIV       = 500000,
  parameter int DB_CYCLES = 500000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Start_Stop_btn,
  input  logic Clear_btn,
`ifdef STOPWATCH_LAP_EN
  input  logic Lap_btn,
  output logic Lap_hold,
`endif
  output logic Enable,
  output logic Clear_out,
  output logic Running,
  output logic Paused
);

  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [PW-1:0]  c_div_max = PW'(DIV - 1);
  localparam logic [DBW-1:0] c_db_max  = DBW'(DB_CYCLES - 1);
  localparam logic [PW-1:0]  c_presc_one = PW'(1);
  localparam logic [DBW-1:0] c_db_one    = DBW'(1);

  localparam int c_btn_ss  = 0;
  localparam int c_btn_clr = 1;
`ifdef STOPWATCH_LAP_EN
  localparam int c_btn_lap = 2;
  localparam int NB        = 3;
`else
  localparam int NB        = 2;
`endif

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_run   = 2'd1;
  localparam logic [1:0] c_pause = 2'd2;

  logic [NB-1:0] w_raw;
  logic [NB-1:0] w_press;

`ifdef STOPWATCH_LAP_EN
  assign w_raw = {Lap_btn, Clear_btn, Start_Stop_btn};
`else
  assign w_raw = {Clear_btn, Start_Stop_btn};
`endif

  // Per button: 2-flop sync, stability counter, rising-edge detect on the debounced level.
  for (genvar gi = 0; gi < NB; gi++) begin : g_btn
    logic           r_sync1;
    logic           r_sync2;
    logic           r_level;
    logic           r_level_d;
    logic [DBW-1:0] r_cnt;

    always_ff @(posedge Clk) begin
      if (Reset) begin
        r_sync1   <= 1'b0;
        r_sync2   <= 1'b0;
        r_level   <= 1'b0;
        r_level_d <= 1'b0;
        r_cnt     <= '0;
      end else begin
        r_sync1   <= w_raw[gi];
        r_sync2   <= r_sync1;
        r_level_d <= r_level;
        if (r_sync2 == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == c_db_max) begin
          r_level <= ~r_level;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + c_db_one;
        end
      end
    end

    assign w_press[gi] = r_level & ~r_level_d;
  end

  logic          w_ss_press;
  logic          w_clr_press;
  logic [1:0]    r_state;
  logic [1:0]    w_next_state;
  logic [PW-1:0] r_presc;
  logic          w_tc;
  logic          w_enable;
  logic          w_clear;
  logic          w_running;
  logic          w_paused;
  logic          r_enable;
  logic          r_clear_out;
  logic          r_running;
  logic          r_paused;

  assign w_ss_press  = w_press[c_btn_ss];
  assign w_clr_press = w_press[c_btn_clr];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Clear beats Start/Stop in IDLE and PAUSE; RUN ignores Clear entirely.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle: begin
        if (w_clr_press)     w_next_state = c_idle;
        else if (w_ss_press) w_next_state = c_run;
      end
      c_run: begin
        if (w_ss_press) w_next_state = c_pause;
      end
      c_pause: begin
        if (w_clr_press)     w_next_state = c_idle;
        else if (w_ss_press) w_next_state = c_run;
      end
      default: w_next_state = c_idle;
    endcase
  end

  always_comb begin
    w_tc      = (r_state == c_run) && (r_presc == c_div_max);
    w_enable  = w_tc;
    w_clear   = w_clr_press && ((r_state == c_idle) || (r_state == c_pause));
    w_running = (w_next_state == c_run);
    w_paused  = (w_next_state == c_pause);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_enable    <= 1'b0;
      r_clear_out <= 1'b0;
      r_running   <= 1'b0;
      r_paused    <= 1'b0;
    end else begin
      r_enable    <= w_enable;
      r_clear_out <= w_clear;
      r_running   <= w_running;
      r_paused    <= w_paused;
    end
  end

  // Counting is keyed on the current state, so the pausing edge still advances
  // the count and PAUSE keeps the partial period for the resume.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_presc <= '0;
    end else if (r_state == c_run) begin
      r_presc <= w_tc ? '0 : (r_presc + c_presc_one);
    end else if (w_next_state == c_idle) begin
      r_presc <= '0;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic r_lap_hold;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_lap_hold <= 1'b0;
    end else if (w_next_state == c_idle) begin
      r_lap_hold <= 1'b0;
    end else if ((r_state == c_run) && w_press[c_btn_lap]) begin
      r_lap_hold <= ~r_lap_hold;
    end
  end

  assign Lap_hold = r_lap_hold;
`endif

  assign Enable    = r_enable;
  assign Clear_out = r_clear_out;
  assign Running   = r_running;
  assign Paused    = r_paused;

endmodule
`default_nettype wire
